outerprodrc_seq: RTL and testbench

- Initiator/sequencer for the outer-product unary GEMM array.
- Accepts one operand tile (row and column vectors for all HIDDEN slices) over a valid/ready handshake and drives the array's enable, clear and data inputs for one full unary window.
- Captures the array's binary sums and returns them over a valid/ready result handshake.
- Sits between the tile-fetch logic and the array; it is the sole driver of the array's control pins.

---
 rtl/outerprodrc_seq_pkg.sv | 28 ++
 rtl/outerprodrc_seq_tilebuf.sv | 93 +++++++++
 rtl/outerprodrc_seq.sv | 153 +++++++++++++++
 tb/tb_outerprodrc_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outerprodrc_seq_pkg.sv
// Shared states, default geometry and width constants for the outer-product sequencer.
package outerprodrc_seq_pkg;

   localparam int HIDDEN_DEF      = 4;
   localparam int ROWNUM_DEF      = 4;
   localparam int COLNUM_DEF      = 4;
   localparam int BITWIDTH_DEF    = 4;
   localparam int OUTBITWIDTH_DEF = 8;
   localparam int SETTLE_DEF      = 1;

   function automatic int win_len(input int bw);
      return 1 << bw;
   endfunction

   localparam int IN0_W   = HIDDEN_DEF * ROWNUM_DEF * BITWIDTH_DEF;
   localparam int IN1_W   = HIDDEN_DEF * COLNUM_DEF * BITWIDTH_DEF;
   localparam int RES_W   = ROWNUM_DEF * COLNUM_DEF * 2 * OUTBITWIDTH_DEF;
   localparam int WIN_LEN = win_len(BITWIDTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_RUN    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

endpackage

// File: rtl/outerprodrc_seq_tilebuf.sv
// Working tile register feeding the array, plus a shadow tile when
// OUTERPRODRC_SEQ_PREFETCH_EN is defined.
module outerprodrc_seq_tilebuf #(
   parameter int D0_W = 64,
   parameter int D1_W = 64
)(
   input  logic            iClk,
   input  logic            iRstN,
   input  logic            iLoad,
   input  logic [D0_W-1:0] iData0,
   input  logic [D1_W-1:0] iData1,
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
   input  logic            iPush,
   input  logic            iPromote,
   input  logic            iFlush,
   output logic            oShadowFull,
`endif
   output logic [D0_W-1:0] oTile0,
   output logic [D1_W-1:0] oTile1
);

   logic [D0_W-1:0] tile0_q, tile0_d;
   logic [D1_W-1:0] tile1_q, tile1_d;

`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
   logic [D0_W-1:0] shadow0_q, shadow0_d;
   logic [D1_W-1:0] shadow1_q, shadow1_d;
   logic            full_q, full_d;

   // Flush only empties the shadow; the working tile keeps its contents.
   always_comb begin
      tile0_d   = tile0_q;
      tile1_d   = tile1_q;
      shadow0_d = shadow0_q;
      shadow1_d = shadow1_q;
      full_d    = full_q;
      if (iFlush) begin
         full_d = 1'b0;
      end else if (iPromote) begin
         tile0_d = shadow0_q;
         tile1_d = shadow1_q;
         full_d  = 1'b0;
      end else begin
         if (iLoad) begin
            tile0_d = iData0;
            tile1_d = iData1;
         end
         if (iPush) begin
            shadow0_d = iData0;
            shadow1_d = iData1;
            full_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         shadow0_q <= '0;
         shadow1_q <= '0;
         full_q    <= 1'b0;
      end else begin
         shadow0_q <= shadow0_d;
         shadow1_q <= shadow1_d;
         full_q    <= full_d;
      end
   end

   assign oShadowFull = full_q;
`else
   always_comb begin
      tile0_d = tile0_q;
      tile1_d = tile1_q;
      if (iLoad) begin
         tile0_d = iData0;
         tile1_d = iData1;
      end
   end
`endif

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         tile0_q <= '0;
         tile1_q <= '0;
      end else begin
         tile0_q <= tile0_d;
         tile1_q <= tile1_d;
      end
   end

   assign oTile0 = tile0_q;
   assign oTile1 = tile1_q;

endmodule

// File: rtl/outerprodrc_seq.sv
// Sequencer for the outer-product unary GEMM array: clear, one unary window, settle, capture.
// Build option: OUTERPRODRC_SEQ_PREFETCH_EN accepts the next tile while the current one runs.
module outerprodrc_seq
   import outerprodrc_seq_pkg::*;
#(
   parameter int HIDDEN      = HIDDEN_DEF,
   parameter int ROWNUM      = ROWNUM_DEF,
   parameter int COLNUM      = COLNUM_DEF,
   parameter int BITWIDTH    = BITWIDTH_DEF,
   parameter int OUTBITWIDTH = OUTBITWIDTH_DEF,
   parameter int SETTLE      = SETTLE_DEF
)(
   input  logic                                   iClk,
   input  logic                                   iRstN,
   input  logic                                   iFlush,
   input  logic                                   iInValid,
   output logic                                   oInReady,
   input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]      iInData0,
   input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]      iInData1,
   output logic                                   oEn,
   output logic                                   oClr,
   output logic [HIDDEN*ROWNUM*BITWIDTH-1:0]      oData0,
   output logic [HIDDEN*COLNUM*BITWIDTH-1:0]      oData1,
   input  logic [ROWNUM*COLNUM*2*OUTBITWIDTH-1:0] iArrSum,
   output logic                                   oOutValid,
   input  logic                                   iOutReady,
   output logic [ROWNUM*COLNUM*2*OUTBITWIDTH-1:0] oOutData,
   output logic                                   oBusy
);

   localparam int D0_W = HIDDEN * ROWNUM * BITWIDTH;
   localparam int D1_W = HIDDEN * COLNUM * BITWIDTH;
   localparam int R_W  = ROWNUM * COLNUM * 2 * OUTBITWIDTH;
   localparam logic [BITWIDTH:0] WIN_LAST    = (BITWIDTH+1)'(win_len(BITWIDTH) - 1);
   localparam logic [2:0]        SETTLE_LAST = 3'(SETTLE - 1);

   state_t            state_q, state_d;
   logic [BITWIDTH:0] win_q, win_d;
   logic [2:0]        settle_q, settle_d;
   logic [R_W-1:0]    res_q, res_d;
   logic              armed_q;

   logic out_valid, handshake, in_ready, accept, load;
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
   logic push, promote, shadow_full;
`endif

   // armed_q keeps oInReady low while reset is held and for the first edge after release.
   assign out_valid = (state_q == ST_HOLD) && !iFlush;
   assign handshake = out_valid && iOutReady;
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
   assign in_ready  = armed_q && !shadow_full && !iFlush;
   assign accept    = iInValid && in_ready;
   assign load      = accept && ((state_q == ST_IDLE) || handshake);
   assign push      = accept && !load;
   assign promote   = handshake && shadow_full;
`else
   assign in_ready  = armed_q && (state_q == ST_IDLE) && !iFlush;
   assign accept    = iInValid && in_ready;
   assign load      = accept;
`endif

   outerprodrc_seq_tilebuf #(
      .D0_W (D0_W),
      .D1_W (D1_W)
   ) u_tilebuf (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .iLoad       (load),
      .iData0      (iInData0),
      .iData1      (iInData1),
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
      .iPush       (push),
      .iPromote    (promote),
      .iFlush      (iFlush),
      .oShadowFull (shadow_full),
`endif
      .oTile0      (oData0),
      .oTile1      (oData1)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      settle_d = settle_q;
      res_d    = res_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
            win_d   = '0;
         end
         ST_RUN: begin
            if (win_q == WIN_LAST) begin
               state_d  = ST_SETTLE;
               win_d    = '0;
               settle_d = '0;
            end else begin
               win_d = win_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               res_d   = iArrSum;
               state_d = ST_HOLD;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (handshake) begin
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
               state_d = (shadow_full || accept) ? ST_CLEAR : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (iFlush) begin
         state_d  = ST_IDLE;
         win_d    = '0;
         settle_d = '0;
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         settle_q <= '0;
         res_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         settle_q <= settle_d;
         res_q    <= res_d;
         armed_q  <= 1'b1;
      end
   end

   assign oInReady  = in_ready;
   assign oEn       = (state_q == ST_RUN) && !iFlush;
   assign oClr      = (state_q == ST_CLEAR) && !iFlush;
   assign oOutValid = out_valid;
   assign oOutData  = res_q;
   assign oBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_outerprodrc_seq.sv
// Randomized scoreboard bench for outerprodrc_seq with a unary-array model driving iArrSum.
module tb_outerprodrc_seq;
   import outerprodrc_seq_pkg::*;

   localparam int H   = HIDDEN_DEF;
   localparam int R   = ROWNUM_DEF;
   localparam int C   = COLNUM_DEF;
   localparam int BW  = BITWIDTH_DEF;
   localparam int OW  = OUTBITWIDTH_DEF;
   localparam int ST  = SETTLE_DEF;
   localparam int LAT = 1 + WIN_LEN + ST + 1;

   logic             iClk = 1'b0;
   logic             iRstN = 1'b0;
   logic             iFlush = 1'b0;
   logic             iInValid = 1'b0;
   logic             iOutReady = 1'b1;
   logic [IN0_W-1:0] iInData0 = '0;
   logic [IN1_W-1:0] iInData1 = '0;
   logic [RES_W-1:0] iArrSum;
   logic             oInReady, oEn, oClr, oOutValid, oBusy;
   logic [IN0_W-1:0] oData0;
   logic [IN1_W-1:0] oData1;
   logic [RES_W-1:0] oOutData;

   outerprodrc_seq #(
      .HIDDEN(H), .ROWNUM(R), .COLNUM(C), .BITWIDTH(BW), .OUTBITWIDTH(OW), .SETTLE(ST)
   ) dut (
      .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush),
      .iInValid(iInValid), .oInReady(oInReady),
      .iInData0(iInData0), .iInData1(iInData1),
      .oEn(oEn), .oClr(oClr), .oData0(oData0), .oData1(oData1),
      .iArrSum(iArrSum), .oOutValid(oOutValid), .iOutReady(iOutReady),
      .oOutData(oOutData), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Unary array model: each enabled step t adds one per slice where both operands exceed t.
   int acc [R][C];
   int en_model = 0;
   int step = 0;

   function automatic int hits(input int r, input int c, input int t);
      int n = 0;
      for (int h = 0; h < H; h++) begin
         if (int'(oData0[(h*R+r)*BW +: BW]) > t && int'(oData1[(h*C+c)*BW +: BW]) > t) n++;
      end
      return n;
   endfunction

   always @(posedge iClk) begin
      if (oClr) begin
         step <= 0;
         en_model <= 0;
         for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) acc[r][c] <= 0;
      end else if (oEn) begin
         step <= step + 1;
         en_model <= en_model + 1;
         for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) acc[r][c] <= acc[r][c] + hits(r, c, step);
      end
   end

   always_comb begin
      iArrSum = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            iArrSum[(r*C+c)*2*OW +: 2*OW] = {OW'(en_model), OW'(acc[r][c])};
   end

   // Full window of unary steps on a tile gives sum over slices of min(row, col).
   function automatic logic [RES_W-1:0] expect_res(input logic [IN0_W-1:0] d0, input logic [IN1_W-1:0] d1);
      logic [RES_W-1:0] e = '0;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            int s = 0;
            for (int h = 0; h < H; h++) begin
               int a = int'(d0[(h*R+r)*BW +: BW]);
               int b = int'(d1[(h*C+c)*BW +: BW]);
               s += (a < b) ? a : b;
            end
            e[(r*C+c)*2*OW +: 2*OW] = {OW'(WIN_LEN), OW'(s)};
         end
      end
      return e;
   endfunction

   logic [RES_W-1:0] exp_q[$];
   int clr_seen = 0, en_seen = 0, valid_seen = 0;

   always @(negedge iClk) begin
      if (!iRstN || iFlush) begin
         exp_q.delete();
      end else begin
         if (oOutValid && iOutReady) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got %0h with nothing outstanding", oOutData);
            end else begin
               check("result_data", oOutData, exp_q.pop_front());
            end
         end
         if (iInValid && oInReady) exp_q.push_back(expect_res(iInData0, iInData1));
      end
      if (oClr) clr_seen++;
      if (oEn) en_seen++;
      if (oOutValid) valid_seen++;
      if (oClr || oEn) check("clr_en_exclusive", oClr & oEn, 0);
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic offer(input logic [IN0_W-1:0] d0, input logic [IN1_W-1:0] d1, output int acc_cyc);
      bit done = 0;
      acc_cyc = -1;
      iInData0 = d0;
      iInData1 = d1;
      iInValid = 1'b1;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge iClk);
         if (oInReady) begin
            done = 1;
            acc_cyc = cyc;
         end
         tick();
      end
      iInValid = 1'b0;
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_valid(output int vc);
      bit done = 0;
      vc = -1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge iClk);
         if (oOutValid) begin
            done = 1;
            vc = cyc;
         end
      end
      if (!done) check("valid_timeout", 0, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, oInReady, 0);
      check({tag, "_en"}, oEn, 0);
      check({tag, "_clr"}, oClr, 0);
      check({tag, "_valid"}, oOutValid, 0);
      check({tag, "_busy"}, oBusy, 0);
      check({tag, "_outdata"}, oOutData, 0);
      check({tag, "_data0"}, oData0, 0);
   endtask

   bit rnd_on = 0;

   initial begin
      logic [IN0_W-1:0] d0;
      logic [IN1_W-1:0] d1;
      logic [RES_W-1:0] held;
      int ac, ac1, vc, vc1, c0, e0, v0;

      // Reset state
      repeat (3) @(posedge iClk);
      #1;
      check_all_zero("reset");
      @(negedge iClk);
      iRstN = 1'b1;
      tick();
      tick();
      @(negedge iClk);
      check("ready_after_reset", oInReady, 1);
      tick();

      // Directed tile: rows 3, cols 5
      d0 = {16{4'd3}};
      d1 = {16{4'd5}};
      c0 = clr_seen;
      e0 = en_seen;
      offer(d0, d1, ac);
      wait_valid(vc);
      check("latency", vc - ac, LAT);
      check("clr_pulses", clr_seen - c0, 1);
      check("en_pulses", en_seen - e0, WIN_LEN);
      tick();
      @(negedge iClk);
      check("valid_drop", oOutValid, 0);
      check("idle_after_hs", oBusy, 0);
      tick();

      // Backpressure in HOLD
      iOutReady = 1'b0;
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      wait_valid(vc);
      tick();
      held = oOutData;
      for (int k = 0; k < 10; k++) begin
         @(negedge iClk);
         check("hold_valid", oOutValid, 1);
         check("hold_data", oOutData, held);
`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
         check("hold_ready", oInReady, 1);
`else
         check("hold_ready", oInReady, 0);
`endif
         tick();
      end
      iOutReady = 1'b1;
      @(negedge iClk);
      check("hold_release_valid", oOutValid, 1);
      tick();
      @(negedge iClk);
      check("release_valid_drop", oOutValid, 0);
      check("release_idle", oBusy, 0);
      tick();

      // Flush at RUN cycle 7
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      repeat (8) tick();
      check("en_before_flush", oEn, 1);
      iFlush = 1'b1;
      #1;
      check("en_during_flush", oEn, 0);
      tick();
      iFlush = 1'b0;
      @(negedge iClk);
      check("flush_idle", oBusy, 0);
      check("flush_en", oEn, 0);
      tick();
      v0 = valid_seen;
      repeat (25) tick();
      check("flush_no_valid", valid_seen - v0, 0);
      c0 = clr_seen;
      e0 = en_seen;
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      wait_valid(vc);
      check("post_flush_clr", clr_seen - c0, 1);
      check("post_flush_en", en_seen - e0, WIN_LEN);
      check("post_flush_latency", vc - ac, LAT);
      tick();
      tick();

      // Asynchronous reset mid-SETTLE
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      repeat (17) tick();
      check("busy_in_settle", oBusy, 1);
      check("en_off_in_settle", oEn, 0);
      #2;
      iRstN = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge iClk);
      #2;
      iRstN = 1'b1;
      tick();
      tick();
      @(negedge iClk);
      check("ready_after_midreset", oInReady, 1);
      check("idle_after_midreset", oBusy, 0);
      tick();

      // Flush coincident with an offer in IDLE
      iInData0 = {$urandom, $urandom};
      iInValid = 1'b1;
      iFlush = 1'b1;
      @(negedge iClk);
      check("flush_blocks_ready", oInReady, 0);
      tick();
      iFlush = 1'b0;
      iInValid = 1'b0;
      check("flush_offer_idle", oBusy, 0);
      check("flush_offer_noclr", oClr, 0);
      tick();

`ifdef OUTERPRODRC_SEQ_PREFETCH_EN
      // Back-to-back tiles through the shadow register
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      tick();
      tick();
      offer({$urandom, $urandom}, {$urandom, $urandom}, ac1);
      check("prefetch_accept_in_run", ac1 - ac, 3);
      wait_valid(vc);
      check("prefetch_latency0", vc - ac, LAT);
      tick();
      @(negedge iClk);
      check("prefetch_clear_follows", oClr, 1);
      tick();
      wait_valid(vc1);
      check("prefetch_spacing", vc1 - vc, 18 + ST);
      tick();
      tick();
`endif

      // Randomized traffic with random result backpressure
      rnd_on = 1;
      fork
         begin
            while (rnd_on) begin
               @(posedge iClk);
               #1;
               iOutReady = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int t = 0; t < 10; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         offer({$urandom, $urandom}, {$urandom, $urandom}, ac);
      end
      rnd_on = 0;
      tick();
      tick();
      iOutReady = 1'b1;
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
      check("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
